// File: rtl/fifo_queue_pkg.sv
// fifo_queue_pkg
// Shared defaults and types for the FIFO queue, its storage and the sibling
// stack/UART buffers that reuse the same word/address sizing.
//   FIFO_DEF_*   default word width, address width and threshold levels
//   fifo_flags_t registered occupancy flags
//   fifo_depth() entry count for a given address width
package fifo_queue_pkg;

  localparam int FIFO_DEF_B        = 4;
  localparam int FIFO_DEF_W        = 4;
  localparam int FIFO_DEF_AF_LEVEL = 14;
  localparam int FIFO_DEF_AE_LEVEL = 2;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int fifo_depth(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/fifo_queue_reg_file_2p.sv
// reg_file_2p
// 2**W x B register file: one synchronous write port, one asynchronous read
// port. Contents are never reset.
//   clk            write clock
//   we/w_addr/w_data  write port, committed on rising edge
//   r_addr/r_data     combinational read port
module reg_file_2p #(
  parameter int B = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem_q [2**W];

  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_queue.sv
// fifo_queue
// First-word-fall-through FIFO: r_data always shows the oldest word.
// Control path (pointers, count, flags, sticky errors) lives here; storage
// is a reg_file_2p.
//   clk, reset        clock, synchronous active-high reset
//   wr, w_data        push request and word
//   rd                pop request (consumes the word shown on r_data)
//   clr_err           clears overflow/underflow (a new error wins)
//   r_data            oldest word (stale when empty)
//   empty, full, almost_empty, almost_full, count   registered occupancy
//   overflow, underflow                             sticky error flags
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int B        = FIFO_DEF_B,
  parameter int W        = FIFO_DEF_W,
  parameter int AF_LEVEL = FIFO_DEF_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_DEF_AE_LEVEL
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int          DEPTH    = fifo_depth(W);
  localparam logic [W:0]  FULL_CNT = (W+1)'(DEPTH);
  localparam logic [W:0]  AF_CNT   = (W+1)'(AF_LEVEL);
  localparam logic [W:0]  AE_CNT   = (W+1)'(AE_LEVEL);
  localparam fifo_flags_t RST_FLAGS = '{
    empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: (AF_LEVEL == 0)
  };

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  fifo_flags_t  flags_q, flags_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         wr_en, rd_en;

  // A write into a full queue is still accepted when a read frees the slot
  // in the same cycle; the read side sees the old word first.
  assign wr_en = wr & (~flags_q.full | rd);
  assign rd_en = rd & ~flags_q.empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_en) w_ptr_d = w_ptr_q + W'(1);
    if (rd_en) r_ptr_d = r_ptr_q + W'(1);

    count_d = count_q + (W+1)'(wr_en) - (W+1)'(rd_en);

    // Flags are registered from next-state count so they line up with count.
    flags_d.empty        = (count_d == '0);
    flags_d.full         = (count_d == FULL_CNT);
    flags_d.almost_empty = (count_d <= AE_CNT);
    flags_d.almost_full  = (count_d >= AF_CNT);

    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr & flags_q.full & ~rd) ovf_d = 1'b1;
    if (rd & flags_q.empty)      unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      flags_q <= RST_FLAGS;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Reset does not gate the write port: pointers restart at 0 and count=0,
  // so any word landing during reset is unreachable.
  reg_file_2p #(.B(B), .W(W)) u_rf (
    .clk    (clk),
    .we     (wr_en),
    .w_addr (w_ptr_q),
    .w_data (w_data),
    .r_addr (r_ptr_q),
    .r_data (r_data)
  );

  assign empty        = flags_q.empty;
  assign full         = flags_q.full;
  assign almost_empty = flags_q.almost_empty;
  assign almost_full  = flags_q.almost_full;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue
// Directed vector table plus hand-written wrap and reset-mid-traffic
// sequences for fifo_queue at B=8, W=2 (depth 4), AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_queue;

  localparam int B = 8;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset, wr, rd, clr_err;
  logic [B-1:0] w_data, r_data;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;
  logic [W:0]   count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_queue #(.B(B), .W(W), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .clr_err      (clr_err),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // status = {count[2:0], empty, full, almost_empty, almost_full, overflow, underflow}
  typedef struct {
    logic       wr, rd, clr, rst;
    logic [7:0] wd;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic [8:0] exp_st;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [8:0] st(input int c, input logic e, f, ae, af, ov, uf);
    logic [2:0] c3;
    c3 = c[2:0];
    return {c3, e, f, ae, af, ov, uf};
  endfunction

  function automatic vec_t mk(input logic w, r, c, rs, input logic [7:0] d,
                              input logic ck, input logic [7:0] er, input logic [8:0] es);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.rst = rs; v.wd = d;
    v.chk_rd = ck; v.exp_rd = er; v.exp_st = es;
    return v;
  endfunction

  function automatic logic [8:0] cur_st();
    return {count, empty, full, almost_empty, almost_full, overflow, underflow};
  endfunction

  // Drive one cycle's inputs, let the edge happen, sample 1ns later.
  task automatic step(input logic w, r, c, rs, input logic [7:0] d);
    wr = w; rd = r; clr_err = c; reset = rs; w_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string name, input logic [8:0] exp);
    checks++;
    if (cur_st() !== exp) begin
      errors++;
      $display("FAIL %s: status got %b want %b ({cnt,e,f,ae,af,ov,uf})", name, cur_st(), exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [7:0] exp);
    checks++;
    if (r_data !== exp) begin
      errors++;
      $display("FAIL %s: r_data got %h want %h", name, r_data, exp);
    end
  endtask

  initial begin
    int maxc;
    wr = 0; rd = 0; clr_err = 0; reset = 0; w_data = '0;

    //                wr rd clr rst  wd     chk  rd     status
    vecs[0]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 0, 0)); // reset
    vecs[1]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 0, 0)); // idle
    vecs[2]  = mk(1, 0, 0, 0, 8'h11, 1, 8'h11, st(1, 0, 0, 1, 0, 0, 0));
    vecs[3]  = mk(1, 0, 0, 0, 8'h22, 1, 8'h11, st(2, 0, 0, 0, 0, 0, 0));
    vecs[4]  = mk(1, 0, 0, 0, 8'h33, 1, 8'h11, st(3, 0, 0, 0, 1, 0, 0));
    vecs[5]  = mk(1, 0, 0, 0, 8'h44, 1, 8'h11, st(4, 0, 1, 0, 1, 0, 0));
    vecs[6]  = mk(1, 0, 0, 0, 8'h55, 1, 8'h11, st(4, 0, 1, 0, 1, 1, 0)); // overflow
    vecs[7]  = mk(1, 1, 0, 0, 8'h66, 1, 8'h22, st(4, 0, 1, 0, 1, 1, 0)); // wr&rd full
    vecs[8]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h33, st(3, 0, 0, 0, 1, 1, 0));
    vecs[9]  = mk(0, 1, 0, 0, 8'h00, 1, 8'h44, st(2, 0, 0, 0, 0, 1, 0));
    vecs[10] = mk(0, 1, 0, 0, 8'h00, 1, 8'h66, st(1, 0, 0, 1, 0, 1, 0));
    vecs[11] = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 1, 0));
    vecs[12] = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 1, 1)); // underflow
    vecs[13] = mk(1, 1, 0, 0, 8'hA5, 1, 8'hA5, st(1, 0, 0, 1, 0, 1, 1)); // wr&rd empty
    vecs[14] = mk(0, 0, 1, 0, 8'h00, 1, 8'hA5, st(1, 0, 0, 1, 0, 0, 0)); // clr_err
    vecs[15] = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 0, 0));
    vecs[16] = mk(0, 1, 1, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 0, 1)); // new error beats clr
    vecs[17] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, st(0, 1, 0, 1, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].rst, vecs[i].wd);
      chk_st($sformatf("vec%0d", i), vecs[i].exp_st);
      if (vecs[i].chk_rd) chk_rd($sformatf("vec%0d", i), vecs[i].exp_rd);
    end

    // Wrap: pointers start at 2 here, ten push/pop pairs carry them past 3.
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'(i);
      step(1, 0, 0, 0, d);
      if (int'(count) > maxc) maxc = int'(count);
      chk_st($sformatf("wrap_wr%0d", i), st(1, 0, 0, 1, 0, 0, 0));
      chk_rd($sformatf("wrap_wr%0d", i), d);
      step(0, 1, 0, 0, 8'h00);
      if (int'(count) > maxc) maxc = int'(count);
      chk_st($sformatf("wrap_rd%0d", i), st(0, 1, 0, 1, 0, 0, 0));
    end
    checks++;
    if (maxc > 1) begin
      errors++;
      $display("FAIL wrap_maxcount: got %0d want <=1", maxc);
    end

    // Reset mid-traffic with a pending error and count=3.
    step(0, 1, 0, 0, 8'h00);
    chk_st("pre_rst_unf", st(0, 1, 0, 1, 0, 0, 1));
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    step(1, 0, 0, 0, 8'h03);
    chk_st("pre_rst_cnt3", st(3, 0, 0, 0, 1, 0, 1));
    chk_rd("pre_rst_cnt3", 8'h01);
    step(1, 1, 0, 1, 8'h04);
    chk_st("rst_mid", st(0, 1, 0, 1, 0, 0, 0));
    step(1, 0, 0, 0, 8'h77);
    chk_st("post_rst_wr", st(1, 0, 0, 1, 0, 0, 0));
    chk_rd("post_rst_wr", 8'h77);
    step(0, 0, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
